apb_bridge_arbiter: RTL and testbench



---
 rtl/apb_bridge_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_bridge_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// apb_bridge_arbiter
//
// Round-robin arbiter that lets NUM_REQ AHB requesters share a single APB
// bridge. An unlocked owner (OWN) keeps the bridge for at most MAX_BEATS
// completed beats while anyone else is waiting. A locked owner (LOCKED) keeps
// it until it drops its request on a completed beat. Hand-over to the next
// requester happens on the release edge itself, with no idle cycle between
// owners.
//
// Ports
//   Hclk        in   clock, all state updates on the rising edge
//   Hresetn     in   asynchronous active-low reset
//   Hbusreq     in   per-requester bus request (bit i = requester i)
//   Hlock       in   per-requester lock request, sampled only when granting
//   Hreadyout   in   bridge beat-complete strobe, one beat per high cycle
//   Hgrant      out  registered one-hot grant, zero when idle
//   Hmaster     out  registered index of the granted requester, 0 when idle
//   Hmastlock   out  registered, high while the current grant is locked
//   Hsel_valid  out  registered, high whenever Hgrant is non-zero
// -----------------------------------------------------------------------------
module apb_bridge_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 8
) (
    input  logic                       Hclk,
    input  logic                       Hresetn,
    input  logic [NUM_REQ-1:0]         Hbusreq,
    input  logic [NUM_REQ-1:0]         Hlock,
    input  logic                       Hreadyout,
    output logic [NUM_REQ-1:0]         Hgrant,
    output logic [$clog2(NUM_REQ)-1:0] Hmaster,
    output logic                       Hmastlock,
    output logic                       Hsel_valid
);

    localparam int         IW         = $clog2(NUM_REQ);
    localparam logic [3:0] BEAT_LIMIT = 4'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        LOCKED
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      master_q;
    logic [IW-1:0]      last_owner_q;
    logic               mastlock_q;
    logic               sel_valid_q;
    logic [3:0]         beat_q;

    logic [NUM_REQ-1:0] rr_req;
    logic [NUM_REQ-1:0] rr_onehot;
    logic [IW-1:0]      rr_idx;
    logic [IW-1:0]      rr_cand;
    logic               rr_found;
    logic               owner_req;
    logic               others_req;
    logic               release_grant;

    // Round-robin search and release decision.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        rr_found  = 1'b0;
        rr_idx    = '0;
        rr_cand   = '0;
        rr_onehot = '0;

        // While someone owns the bridge the current owner is excluded, so a
        // release always hands over to a different requester (or to IDLE).
        rr_req = (state_q == IDLE) ? Hbusreq : (Hbusreq & ~grant_q);

        // Search starts one past the last owner and wraps; the first hit wins.
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_cand = last_owner_q + IW'(i);
            if (!rr_found && rr_req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
        rr_onehot[rr_idx] = 1'b1;

        owner_req  = |(Hbusreq & grant_q);
        others_req = |(Hbusreq & ~grant_q);

        // Releases only ever happen on a completed beat. The beat limit only
        // forces a hand-over for unlocked owners with someone else waiting.
        release_grant = Hreadyout &&
                        (!owner_req ||
                         (state_q == OWN && beat_q == BEAT_LIMIT && others_req));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            master_q     <= '0;
            mastlock_q   <= 1'b0;
            sel_valid_q  <= 1'b0;
            beat_q       <= '0;
            // Pointing at the highest index makes requester 0 win first.
            last_owner_q <= IW'(NUM_REQ - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rr_found) begin
                        state_q      <= Hlock[rr_idx] ? LOCKED : OWN;
                        grant_q      <= rr_onehot;
                        master_q     <= rr_idx;
                        mastlock_q   <= Hlock[rr_idx];
                        sel_valid_q  <= 1'b1;
                        beat_q       <= '0;
                        last_owner_q <= rr_idx;
                    end
                end

                OWN, LOCKED: begin
                    if (release_grant) begin
                        if (rr_found) begin
                            state_q      <= Hlock[rr_idx] ? LOCKED : OWN;
                            grant_q      <= rr_onehot;
                            master_q     <= rr_idx;
                            mastlock_q   <= Hlock[rr_idx];
                            sel_valid_q  <= 1'b1;
                            last_owner_q <= rr_idx;
                        end else begin
                            state_q     <= IDLE;
                            grant_q     <= '0;
                            master_q    <= '0;
                            mastlock_q  <= 1'b0;
                            sel_valid_q <= 1'b0;
                        end
                        beat_q <= '0;
                    end else if (state_q == OWN && Hreadyout &&
                                 beat_q != BEAT_LIMIT) begin
                        // Locked owners are not beat-limited, so only count in OWN.
                        beat_q <= beat_q + 4'd1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    grant_q     <= '0;
                    master_q    <= '0;
                    mastlock_q  <= 1'b0;
                    sel_valid_q <= 1'b0;
                    beat_q      <= '0;
                end
            endcase
        end
    end

    assign Hgrant     = grant_q;
    assign Hmaster    = master_q;
    assign Hmastlock  = mastlock_q;
    assign Hsel_valid = sel_valid_q;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_bridge_arbiter
//
// Directed bench for apb_bridge_arbiter (NUM_REQ = 4, MAX_BEATS = 8). Each
// scenario task drives inputs right after a rising edge and checks the
// registered outputs 1 time unit after the edge that produced them. A
// negedge monitor checks the one-hot / Hsel_valid invariants every cycle.
// -----------------------------------------------------------------------------
module tb_apb_bridge_arbiter;

    logic       Hclk;
    logic       Hresetn;
    logic [3:0] Hbusreq;
    logic [3:0] Hlock;
    logic       Hreadyout;
    logic [3:0] Hgrant;
    logic [1:0] Hmaster;
    logic       Hmastlock;
    logic       Hsel_valid;

    int n_checks = 0;
    int n_passed = 0;

    apb_bridge_arbiter #(
        .NUM_REQ  (4),
        .MAX_BEATS(8)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq   (Hbusreq),
        .Hlock     (Hlock),
        .Hreadyout (Hreadyout),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Hmastlock (Hmastlock),
        .Hsel_valid(Hsel_valid)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Invariants, checked every cycle away from the active edge.
    always @(negedge Hclk) begin
        n_checks++;
        if (!$onehot0(Hgrant) || (Hsel_valid !== (|Hgrant))) begin
            $display("FAIL invariant t=%0t: Hgrant=%b Hsel_valid=%b (need one-hot-or-zero and Hsel_valid=|Hgrant)",
                     $time, Hgrant, Hsel_valid);
        end else begin
            n_passed++;
        end
    end

    a_onehot: assert property (@(posedge Hclk) disable iff (!Hresetn)
                               $onehot0(Hgrant) && (Hsel_valid == (|Hgrant)));

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic do_reset();
        Hresetn   = 1'b0;
        Hbusreq   = 4'b0000;
        Hlock     = 4'b0000;
        Hreadyout = 1'b0;
        #2;
        Hresetn   = 1'b1;
    endtask

    task automatic check_out(input string name, input logic [3:0] exp_grant,
                             input logic [1:0] exp_master, input logic exp_lock);
        n_checks++;
        if (Hgrant !== exp_grant || Hmaster !== exp_master ||
            Hmastlock !== exp_lock || Hsel_valid !== (|exp_grant)) begin
            $display("FAIL %s t=%0t: got grant=%b master=%0d lock=%b sel=%b, expected grant=%b master=%0d lock=%b sel=%b",
                     name, $time, Hgrant, Hmaster, Hmastlock, Hsel_valid,
                     exp_grant, exp_master, exp_lock, |exp_grant);
        end else begin
            n_passed++;
        end
    endtask

    task automatic test_reset();
        Hresetn   = 1'b0;
        Hbusreq   = 4'b1111;
        Hlock     = 4'b1111;
        Hreadyout = 1'b1;
        tick();
        check_out("reset_hold", 4'b0000, 2'd0, 1'b0);
        do_reset();
        tick();
        check_out("idle_no_req", 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_basic();
        do_reset();
        Hbusreq = 4'b0001;
        tick();
        check_out("basic_grant", 4'b0001, 2'd0, 1'b0);
        Hbusreq   = 4'b0000;
        Hreadyout = 1'b1;
        tick();
        check_out("basic_release", 4'b0000, 2'd0, 1'b0);
        tick();
        check_out("basic_stay_idle", 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_rotation();
        int owners[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp;
        do_reset();
        Hbusreq   = 4'b1111;
        Hreadyout = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << owners[k];
            for (int c = 0; c < 8; c++) begin
                check_out($sformatf("rotate_owner%0d_beat%0d", owners[k], c),
                          exp, 2'(owners[k]), 1'b0);
                tick();
            end
        end
        Hbusreq = 4'b0000;
        tick();
        check_out("rotate_to_idle", 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_saturate();
        do_reset();
        Hbusreq   = 4'b0001;
        Hreadyout = 1'b1;
        tick();
        for (int c = 0; c < 12; c++) begin
            check_out($sformatf("alone_beat%0d", c), 4'b0001, 2'd0, 1'b0);
            tick();
        end
        // Counter is saturated at the limit, so a newcomer takes over at once.
        Hbusreq = 4'b0011;
        tick();
        check_out("saturated_handover", 4'b0010, 2'd1, 1'b0);
    endtask

    task automatic test_locked();
        do_reset();
        Hbusreq = 4'b0100;
        Hlock   = 4'b0100;
        tick();
        check_out("lock_grant", 4'b0100, 2'd2, 1'b1);
        Hbusreq   = 4'b1111;
        Hlock     = 4'b0000;
        Hreadyout = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_out($sformatf("lock_hold%0d", c), 4'b0100, 2'd2, 1'b1);
        end
        Hbusreq   = 4'b1011;
        Hreadyout = 1'b0;
        tick();
        check_out("lock_drop_not_ready", 4'b0100, 2'd2, 1'b1);
        Hreadyout = 1'b1;
        tick();
        check_out("lock_release_next", 4'b1000, 2'd3, 1'b0);
    endtask

    task automatic test_drop_while_busy();
        do_reset();
        Hbusreq = 4'b0010;
        tick();
        check_out("drop_grant", 4'b0010, 2'd1, 1'b0);
        Hbusreq   = 4'b0101;
        Hlock     = 4'b1111;
        Hreadyout = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out($sformatf("drop_hold%0d", c), 4'b0010, 2'd1, 1'b0);
        end
        Hlock     = 4'b0000;
        Hreadyout = 1'b1;
        tick();
        // Round-robin from owner 1 picks 2 before 0.
        check_out("drop_handover", 4'b0100, 2'd2, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        Hbusreq   = 4'b1000;
        Hreadyout = 1'b1;
        tick();
        check_out("areset_grant", 4'b1000, 2'd3, 1'b0);
        tick();
        tick();
        #1;
        Hresetn = 1'b0;
        #1;
        check_out("areset_immediate", 4'b0000, 2'd0, 1'b0);
        #2;
        Hresetn = 1'b1;
        tick();
        check_out("areset_regrant", 4'b1000, 2'd3, 1'b0);
    endtask

    initial begin
        Hresetn   = 1'b0;
        Hbusreq   = 4'b0000;
        Hlock     = 4'b0000;
        Hreadyout = 1'b0;
        test_reset();
        test_basic();
        test_rotation();
        test_saturate();
        test_locked();
        test_drop_while_busy();
        test_async_reset();
        @(posedge Hclk);
        #1;
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
